// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch-condition evaluator: operand width and
// branch operation encodings ({1'b1, funct3} for conditional branches).
package branch_unit_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      BU_NONE = 4'b0000,
      BU_JUMP = 4'b0001,
      BU_EQ   = 4'b1000,
      BU_NE   = 4'b1001,
      BU_LT   = 4'b1100,
      BU_GE   = 4'b1101,
      BU_LTU  = 4'b1110,
      BU_GEU  = 4'b1111
   } bu_op_t;

endpackage

// File: rtl/branch_unit_cmp.sv
// Combinational operand comparator: equality, signed less-than and unsigned
// less-than over the full operand width, with no extension.
module branch_unit_cmp
   import branch_unit_pkg::*;
#(
   parameter int XLEN = branch_unit_pkg::XLEN
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            eq,
   output logic            lt_s,
   output logic            lt_u
);

   assign eq   = (a == b);
   assign lt_u = (a < b);
   assign lt_s = ($signed(a) < $signed(b));

endmodule

// File: rtl/branch_unit.sv
// RV32 branch-condition evaluator: combinational take flag for PC select plus
// a registered, valid-qualified copy for the pipeline/flush logic.
module branch_unit
   import branch_unit_pkg::*;
#(
   parameter int XLEN = branch_unit_pkg::XLEN
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  logic [3:0]      i_op,
   input  logic            i_valid,
   output logic            o_take,
   output logic            o_take_q,
   output logic            o_valid_q
);

   logic eq;
   logic lt_s;
   logic lt_u;
   logic take;

   branch_unit_cmp #(.XLEN(XLEN)) u_cmp (
      .a    (i_a),
      .b    (i_b),
      .eq   (eq),
      .lt_s (lt_s),
      .lt_u (lt_u)
   );

   // Encodings outside the enum fall through to not-taken.
   always_comb begin
      take = 1'b0;
      case (i_op)
         BU_NONE: take = 1'b0;
         BU_JUMP: take = 1'b1;
         BU_EQ:   take = eq;
         BU_NE:   take = ~eq;
         BU_LT:   take = lt_s;
         BU_GE:   take = ~lt_s;
         BU_LTU:  take = lt_u;
         BU_GEU:  take = ~lt_u;
         default: take = 1'b0;
      endcase
   end

   assign o_take = take;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_take_q  <= 1'b0;
         o_valid_q <= 1'b0;
      end else begin
         o_take_q  <= i_valid & take;
         o_valid_q <= i_valid;
      end
   end

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed boundary cases followed by
// randomized operands/ops/valid/reset against an arithmetic reference model.
module tb_branch_unit;
   import branch_unit_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic [3:0]  i_op;
   logic        i_valid;
   logic        o_take;
   logic        o_take_q;
   logic        o_valid_q;

   int checks = 0;
   int errors = 0;

   branch_unit dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_a       (i_a),
      .i_b       (i_b),
      .i_op      (i_op),
      .i_valid   (i_valid),
      .o_take    (o_take),
      .o_take_q  (o_take_q),
      .o_valid_q (o_valid_q)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference decision from the RISC-V branch rules, using plain integer math.
   function automatic logic model_take(input int op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (op)
         1:       return 1'b1;
         8:       return ua == ub;
         9:       return ua != ub;
         12:      return sa <  sb;
         13:      return sa >= sb;
         14:      return ua <  ub;
         15:      return ua >= ub;
         default: return 1'b0;
      endcase
   endfunction

   task automatic comb(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic exp);
      i_a = a; i_b = b; i_op = op;
      #1;
      check(tag, {31'd0, o_take}, {31'd0, exp});
   endtask

   logic        exp_tq;
   logic        exp_vq;
   logic [31:0] ra, rb;
   logic [3:0]  rop;
   logic [3:0]  ops [8];

   initial begin
      ops = '{4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
      i_rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0; i_op = 4'b0000;

      // reset held for two edges
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_take_q", {31'd0, o_take_q}, 32'd0);
      check("rst_valid_q", {31'd0, o_valid_q}, 32'd0);

      // directed combinational cases
      comb("eq_1_1", 32'd1, 32'd1, 4'b1000, 1'b1);
      comb("ne_1_1", 32'd1, 32'd1, 4'b1001, 1'b0);
      comb("lt_2_3", 32'd2, 32'd3, 4'b1100, 1'b1);
      comb("ge_2_3", 32'd2, 32'd3, 4'b1101, 1'b0);
      comb("ltu_m1_3", 32'hFFFF_FFFF, 32'd3, 4'b1110, 1'b0);
      comb("geu_m1_3", 32'hFFFF_FFFF, 32'd3, 4'b1111, 1'b1);
      comb("lt_m1_3", 32'hFFFF_FFFF, 32'd3, 4'b1100, 1'b1);
      comb("ge_m1_3", 32'hFFFF_FFFF, 32'd3, 4'b1101, 1'b0);
      comb("lt_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 4'b1100, 1'b1);
      comb("ltu_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 4'b1110, 1'b0);
      comb("jump", 32'h8000_0000, 32'h7FFF_FFFF, 4'b0001, 1'b1);
      comb("none", 32'h8000_0000, 32'h7FFF_FFFF, 4'b0000, 1'b0);
      comb("op_0110", 32'h8000_0000, 32'h7FFF_FFFF, 4'b0110, 1'b0);
      comb("lt_m1_0", 32'hFFFF_FFFF, 32'd0, 4'b1100, 1'b1);
      comb("ltu_m1_0", 32'hFFFF_FFFF, 32'd0, 4'b1110, 1'b0);
      comb("lt_eq", 32'd7, 32'd7, 4'b1100, 1'b0);
      comb("ltu_eq", 32'd7, 32'd7, 4'b1110, 1'b0);
      comb("ge_eq", 32'd7, 32'd7, 4'b1101, 1'b1);
      comb("geu_eq", 32'd7, 32'd7, 4'b1111, 1'b1);

      // clocked path
      i_rst = 1'b0; i_valid = 1'b1; i_a = 32'd5; i_b = 32'd5; i_op = 4'b1000;
      @(posedge i_clk); @(negedge i_clk);
      check("clk_take_q", {31'd0, o_take_q}, 32'd1);
      check("clk_valid_q", {31'd0, o_valid_q}, 32'd1);
      i_valid = 1'b0;
      @(posedge i_clk); @(negedge i_clk);
      check("inval_take_q", {31'd0, o_take_q}, 32'd0);
      check("inval_valid_q", {31'd0, o_valid_q}, 32'd0);

      // reset mid-operation
      i_valid = 1'b1;
      @(posedge i_clk); @(negedge i_clk);
      check("pre_rst_take_q", {31'd0, o_take_q}, 32'd1);
      i_rst = 1'b1;
      @(posedge i_clk); @(negedge i_clk);
      check("mid_rst_take_q", {31'd0, o_take_q}, 32'd0);
      check("mid_rst_valid_q", {31'd0, o_valid_q}, 32'd0);
      check("mid_rst_take", {31'd0, o_take}, 32'd1);
      i_b = 32'd6;
      #1;
      check("mid_rst_take_track", {31'd0, o_take}, 32'd0);

      // randomized run: drive on negedge, check comb at once, registered next negedge
      exp_tq = 1'b0; exp_vq = 1'b0;
      for (int n = 0; n < 500; n++) begin
         ra = $urandom;
         case ($urandom_range(0, 4))
            0: rb = ra;
            1: rb = ra ^ 32'h8000_0000;
            2: rb = ra + 32'd1;
            default: rb = $urandom;
         endcase
         rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 7)];
         i_a = ra; i_b = rb; i_op = rop;
         i_valid = 1'($urandom_range(0, 1));
         i_rst = ($urandom_range(0, 15) == 0);
         #1;
         check("rnd_take", {31'd0, o_take}, {31'd0, model_take(int'(rop), ra, rb)});
         exp_vq = i_rst ? 1'b0 : i_valid;
         exp_tq = i_rst ? 1'b0 : (i_valid & model_take(int'(rop), ra, rb));
         @(posedge i_clk); @(negedge i_clk);
         check("rnd_take_q", {31'd0, o_take_q}, {31'd0, exp_tq});
         check("rnd_valid_q", {31'd0, o_valid_q}, {31'd0, exp_vq});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- RV32 branch-condition evaluator in the execute stage of the cotm32 core.
- Compares two XLEN operands under a branch opcode and asserts a combinational take flag, which the PC-select logic consumes in the same cycle.
- Also provides a one-cycle registered copy of the decision, qualified by a valid bit, for the pipeline/flush logic.

Parameters:
- XLEN, 32 (from the shared `XLEN define), operand width in bits.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_a  input  XLEN  operand A (rs1 value).
- i_b  input  XLEN  operand B (rs2 value).
- i_op  input  4 (bu_op_t)  branch operation select.
- i_valid  input  1  current op is a real instruction; gates the registered output only.
- o_take  output  1  combinational branch decision.
- o_take_q  output  1  registered o_take, qualified by i_valid.
- o_valid_q  output  1  registered i_valid.

Behaviour:
- o_take is purely combinational from i_a, i_b, i_op. Zero latency; it must settle within the same cycle, with no dependence on i_clk, i_rst or i_valid.
- bu_op_t encodings are {1'b1, RISC-V funct3} for branches:
  - BU_EQ=4'b1000: take = (a == b).
  - BU_NE=4'b1001: take = (a != b).
  - BU_LT=4'b1100: take = signed(a) < signed(b).
  - BU_GE=4'b1101: take = signed(a) >= signed(b).
  - BU_LTU=4'b1110: take = unsigned(a) < unsigned(b).
  - BU_GEU=4'b1111: take = unsigned(a) >= unsigned(b).
  - BU_NONE=4'b0000: take = 0.
  - BU_JUMP=4'b0001: take = 1 (JAL/JALR).
  - Every other encoding: take = 0.
- Signed and unsigned comparisons interpret the full XLEN bits in two's complement or unsigned form respectively. No operand extension.
- Boundaries:
  - a == b gives LT/LTU = 0 and GE/GEU = 1.
  - 0x8000_0000 vs 0x7FFF_FFFF: LT = 1, LTU = 0.
  - 0xFFFF_FFFF vs 0: LT = 1, LTU = 0.
- Registered path, updated on rising i_clk:
  - If i_rst: o_take_q <= 0 and o_valid_q <= 0.
  - Else: o_valid_q <= i_valid and o_take_q <= i_valid & o_take.
- Reset values: o_take_q = 0, o_valid_q = 0. o_take has no reset value; it is combinational.
- Reset asserted mid-stream clears the registered outputs on the next edge. o_take keeps tracking its inputs while reset is held.
- i_valid = 0 forces o_take_q to 0 on the next edge, regardless of the op.
- The design contains no X-propagation masking. Unknown i_op values map to take = 0 through a default arm.

Decomposition:
- Shared package/defs.svh holds the `XLEN define and the bu_op_t enum (4-bit logic) with BU_NONE, BU_JUMP, BU_EQ, BU_NE, BU_LT, BU_GE, BU_LTU, BU_GEU.
- The decoder that maps funct3 to bu_op_t lives in the control unit, not here.
- One sub-module is natural: bu_cmp, a combinational comparator producing eq, lt_s and lt_u flags. The top-level selects among these and adds the output register.

Test Plan:
- a=1, b=1: op=BU_EQ -> o_take=1; op=BU_NE -> o_take=0.
- a=2, b=3: op=BU_LT -> o_take=1; op=BU_GE -> o_take=0.
- a=0xFFFF_FFFF (-1), b=3: op=BU_LTU -> 0; BU_GEU -> 1; BU_LT -> 1; BU_GE -> 0.
- a=0x8000_0000, b=0x7FFF_FFFF: BU_LT -> 1; BU_LTU -> 0. Then op=BU_JUMP -> 1, BU_NONE -> 0, 4'b0110 -> 0.
- Clocked path:
  - i_rst=1 for 2 edges -> o_take_q=0, o_valid_q=0.
  - Release reset, drive i_valid=1, BU_EQ, a=b=5 -> after next edge o_take_q=1, o_valid_q=1.
  - Drive i_valid=0 -> after next edge o_take_q=0, o_valid_q=0.
- Reset mid-operation: with o_take_q=1, assert i_rst for one edge -> o_take_q=0 and o_valid_q=0 on that edge, while o_take still reflects the inputs combinationally.
